acq_sequencer: RTL

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_pkg.sv | 22 ++
 rtl/adc_spi_rx.sv | 92 +++++++++
 rtl/acq_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: FSM state encoding and
// fixed timing/averaging constants. Used by acq_sequencer and adc_spi_rx.
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        WAIT_BUSY,
        READ,
        STORE,
        DONE
    } state_t;

    // Width of the adc_cnv pulse in clk cycles
    localparam int CNV_PULSE_CYC = 2;

    // log2 of the number of conversions averaged per channel (ACQ_AVERAGING_EN builds)
    localparam int AVG_LOG2 = 2;
    localparam int AVG_CNT  = 1 << AVG_LOG2;

endpackage

// File: rtl/adc_spi_rx.sv
// ADC serial read-out: generates DATA_W adc_sck pulses (idle low, SCK_HALF clk
// cycles per half period), shifts miso in MSB first on each rising sck edge and
// raises done_o for one cycle together with the final falling edge.
// abort_i stops a transfer immediately and parks sck low.
module adc_spi_rx #(
    parameter int DATA_W   = 16,
    parameter int SCK_HALF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              miso_i,
    output logic              sck_o,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);

    localparam int HC_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BC_W = $clog2(DATA_W);

    logic              active_q, active_d;
    logic              sck_q, sck_d;
    logic [HC_W-1:0]   half_q, half_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              done_q, done_d;

    // Half-period timer, sck toggling, shift-in on rising sck and bit counting
    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        half_d   = half_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
        if (abort_i) begin
            active_d = 1'b0;
            sck_d    = 1'b0;
            half_d   = '0;
            bit_d    = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            half_d   = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (half_q == HC_W'(SCK_HALF - 1)) begin
                half_d = '0;
                if (!sck_q) begin
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[DATA_W-2:0], miso_i};
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == BC_W'(DATA_W - 1)) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        bit_d    = '0;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end else begin
                half_d = half_q + HC_W'(1);
            end
        end
    end

    // Transfer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            half_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            done_q   <= done_d;
        end
    end

    assign sck_o  = sck_q;
    assign data_o = shreg_q;
    assign done_o = done_q;

endmodule

// File: rtl/acq_sequencer.sv
// Multi-channel acquisition sequencer: on each start it walks analog mux
// channels 0..NUM_CH-1, settling, converting and reading one ADC result per
// channel, then signals cycle_done. All outputs are registered.
// Optional build macro ACQ_AVERAGING_EN: each channel is converted AVG_CNT
// times and the truncated mean is reported as one sample.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int DATA_W     = 16,
    parameter int SCK_HALF   = 2,
    parameter int SETTLE_CYC = 8,
    parameter int BUSY_TMO   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    output logic                      adc_cnv,
    input  logic                      adc_busy,
    output logic                      adc_sck,
    input  logic                      adc_miso,
    output logic [$clog2(NUM_CH)-1:0] analog_mux_chn,
    output logic                      sample_valid,
    output logic [DATA_W-1:0]         sample_data,
    output logic [$clog2(NUM_CH)-1:0] sample_chn,
    output logic                      cycle_done,
    output logic                      overrun,
    output logic                      timeout
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CNT_MAX = (SETTLE_CYC > BUSY_TMO) ? SETTLE_CYC : BUSY_TMO;
    localparam int CNT_W   = $clog2(CNT_MAX + CNV_PULSE_CYC + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     mux_q, mux_d;
    logic [CH_W-1:0]     chn_q, chn_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cnv_q, cnv_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                tmo_q, tmo_d;

    logic                spi_start;
    logic                spi_abort;
    logic                spi_done;
    logic [DATA_W-1:0]   spi_data;

`ifdef ACQ_AVERAGING_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] conv_q, conv_d;
`endif

    adc_spi_rx #(
        .DATA_W   (DATA_W),
        .SCK_HALF (SCK_HALF)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .start_i (spi_start),
        .abort_i (spi_abort),
        .miso_i  (adc_miso),
        .sck_o   (adc_sck),
        .data_o  (spi_data),
        .done_o  (spi_done)
    );

    // Scan FSM: next state, counters, and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mux_d     = mux_q;
        chn_d     = chn_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        ovr_d     = start && (state_q != IDLE);
        spi_start = 1'b0;
        spi_abort = !enable;
`ifdef ACQ_AVERAGING_EN
        acc_d     = acc_q;
        conv_d    = conv_q;
        sum       = acc_q + ACC_W'(spi_data);
`endif
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            mux_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SETTLE;
                        mux_d   = '0;
                        cnt_d   = '0;
                    end
                end
                SETTLE: begin
                    if (int'(cnt_q) + 1 >= SETTLE_CYC) begin
                        state_d = CONVERT;
                        cnt_d   = '0;
`ifdef ACQ_AVERAGING_EN
                        acc_d   = '0;
                        conv_d  = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (cnt_q == CNT_W'(CNV_PULSE_CYC - 1)) begin
                        state_d = WAIT_BUSY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_BUSY: begin
                    if (!adc_busy) begin
                        spi_start = 1'b1;
                        state_d   = READ;
                        cnt_d     = '0;
                    end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                        // ADC never answered: report an all-ones sample and move on
                        tmo_d   = 1'b1;
                        data_d  = '1;
                        chn_d   = mux_q;
                        valid_d = 1'b1;
                        state_d = STORE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                READ: begin
                    if (spi_done) begin
`ifdef ACQ_AVERAGING_EN
                        if (conv_q == AVG_LOG2'(AVG_CNT - 1)) begin
                            data_d  = sum[ACC_W-1:AVG_LOG2];
                            chn_d   = mux_q;
                            valid_d = 1'b1;
                            state_d = STORE;
                        end else begin
                            // Same channel again: no re-settle between conversions
                            acc_d   = sum;
                            conv_d  = conv_q + AVG_LOG2'(1);
                            state_d = CONVERT;
                            cnt_d   = '0;
                        end
`else
                        data_d  = spi_data;
                        chn_d   = mux_q;
                        valid_d = 1'b1;
                        state_d = STORE;
`endif
                    end
                end
                STORE: begin
                    if (mux_q < CH_W'(NUM_CH - 1)) begin
                        mux_d   = mux_q + CH_W'(1);
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    mux_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        cnv_d = (state_d == CONVERT);
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mux_q   <= '0;
            chn_q   <= '0;
            data_q  <= '0;
            cnv_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef ACQ_AVERAGING_EN
            acc_q   <= '0;
            conv_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            chn_q   <= chn_d;
            data_q  <= data_d;
            cnv_q   <= cnv_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
`ifdef ACQ_AVERAGING_EN
            acc_q   <= acc_d;
            conv_q  <= conv_d;
`endif
        end
    end

    assign adc_cnv        = cnv_q;
    assign analog_mux_chn = mux_q;
    assign sample_valid   = valid_q;
    assign sample_data    = data_q;
    assign sample_chn     = chn_q;
    assign cycle_done     = done_q;
    assign overrun        = ovr_q;
    assign timeout        = tmo_q;

endmodule
